pokemon_frame_renderer: RTL and testbench

- Consumer end of the game-logic state bus: takes lane/ball/shield/health state from Pokemon_Logic and turns it into 16-bit RGB565 pixels for the 96x64 OLED driver.
- Latches a tear-free snapshot of game state once per frame and renders through a 2-stage pixel pipeline.
- Runs per-character hit-flash and dead-grey animation from frame-to-frame health changes.

---
 rtl/pokemon_render_pkg.sv | 73 +++++++
 rtl/pokemon_flash_timer.sv | 45 ++++
 rtl/pokemon_frame_renderer.sv | 196 +++++++++++++++++++
 tb/tb_pokemon_frame_renderer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pokemon_render_pkg.sv
// Shared geometry, colours and snapshot/hit layouts for the frame renderer.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package pokemon_render_pkg;

  localparam int SCREEN_W  = 96;
  localparam int SCREEN_H  = 64;
  localparam int PIXELS    = SCREEN_W * SCREEN_H;
  localparam int BALL_SIZE = 8;
  localparam int CHAR_H    = 18;
  localparam int NUM_BALLS = 12;

  // Geometry is kept 8 bits wide so that "top + height" never wraps.
  localparam logic [7:0] LANE_TOP [3] = '{8'd1, 8'd19, 8'd37};
  localparam logic [7:0] BALL_TOP [3] = '{8'd6, 8'd24, 8'd42};

  localparam logic [7:0] CHAR_C_X0   = 8'd1;
  localparam logic [7:0] CHAR_C_X1   = 8'd16;
  localparam logic [7:0] CHAR_S_X0   = 8'd79;
  localparam logic [7:0] CHAR_S_X1   = 8'd94;
  localparam logic [7:0] SHIELD_C_X0 = 8'd17;
  localparam logic [7:0] SHIELD_C_X1 = 8'd18;
  localparam logic [7:0] SHIELD_S_X0 = 8'd77;
  localparam logic [7:0] SHIELD_S_X1 = 8'd78;

  localparam logic [15:0] DEF_COL_BG     = 16'h0000;
  localparam logic [15:0] DEF_COL_FIRE   = 16'hF800;
  localparam logic [15:0] DEF_COL_WATER  = 16'h001F;
  localparam logic [15:0] DEF_COL_CHAR   = 16'hFC00;
  localparam logic [15:0] DEF_COL_SQUIR  = 16'h07FF;
  localparam logic [15:0] DEF_COL_SHIELD = 16'hFFE0;
  localparam logic [15:0] DEF_COL_HP     = 16'h07E0;
  localparam logic [15:0] DEF_COL_DEAD   = 16'h8410;
  localparam logic [15:0] COL_WHITE      = 16'hFFFF;

  // Game state frozen at frame_begin; rendering never looks at live inputs.
  typedef struct packed {
    logic [5:0]                  top_c;
    logic [5:0]                  top_s;
    logic [NUM_BALLS-1:0]        fb_en;
    logic [NUM_BALLS-1:0]        wb_en;
    logic [NUM_BALLS-1:0][6:0]   fb_x;
    logic [NUM_BALLS-1:0][6:0]   wb_x;
    logic [5:0]                  shield;
    logic                        alive_c;
    logic                        alive_s;
    logic [5:0]                  bar_c;
    logic [5:0]                  bar_s;
  } snap_t;

  // Per-pixel layer hits handed from stage 1 to the stage 2 priority mux.
  typedef struct packed {
    logic oob;
    logic hp;
    logic shield;
    logic chr_c;
    logic chr_s;
    logic chr_dead;
    logic chr_white;
    logic fire;
    logic water;
  } hit_t;

  function automatic logic [6:0] clamp_health(input logic [31:0] h);
    return (h > 32'd100) ? 7'd100 : h[6:0];
  endfunction

  function automatic logic in_span(input logic [7:0] v, input logic [7:0] lo,
                                   input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pokemon_flash_timer.sv
// Per-character hit-flash timer: reloads on a health drop, counts down per frame.
// Latency: counter and flash phase update on the frame_begin edge.
// Backpressure: none; advances only on frame_begin.
module pokemon_flash_timer #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_begin,
  input  logic [6:0] health,
  output logic       flash
);

  logic [7:0] cnt_q, cnt_d;
  logic [6:0] prev_q, prev_d;

  // A drop versus the previous snapshot reloads (and beats the decrement).
  always_comb begin
    cnt_d  = cnt_q;
    prev_d = prev_q;
    if (frame_begin) begin
      prev_d = health;
      if (health < prev_q) begin
        cnt_d = 8'(FLASH_FRAMES);
      end else if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // Counter and previous-health registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 8'd0;
      prev_q <= 7'd100;
    end else begin
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

  // White on counter values with bit 1 set gives a two-on/two-off blink.
  assign flash = (cnt_q != 8'd0) && cnt_q[1];

endmodule

// File: rtl/pokemon_frame_renderer.sv
// Renders snapshotted game state into RGB565 pixels for the 96x64 OLED.
// Latency: pixel_valid/oled_data two clocks after the request is captured.
// Backpressure: none; accepts one pixel_req per cycle.
module pokemon_frame_renderer
  import pokemon_render_pkg::*;
#(
  parameter int          FLASH_FRAMES = 8,
  parameter int          BAR_MAX      = 40,
  parameter logic [15:0] COL_BG       = DEF_COL_BG,
  parameter logic [15:0] COL_FIRE     = DEF_COL_FIRE,
  parameter logic [15:0] COL_WATER    = DEF_COL_WATER,
  parameter logic [15:0] COL_CHAR     = DEF_COL_CHAR,
  parameter logic [15:0] COL_SQUIR    = DEF_COL_SQUIR,
  parameter logic [15:0] COL_SHIELD   = DEF_COL_SHIELD,
  parameter logic [15:0] COL_HP       = DEF_COL_HP,
  parameter logic [15:0] COL_DEAD     = DEF_COL_DEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic        pixel_req,
  input  logic        frame_begin,
  input  logic [5:0]  topYCharmander,
  input  logic [5:0]  topYSquirtle,
  input  logic [11:0] FireBall_EN,
  input  logic [11:0] WaterBall_EN,
  input  logic [83:0] leftX_fb_flat,
  input  logic [83:0] leftX_wb_flat,
  input  logic [5:0]  Shield_EN,
  input  logic        Charmander_Alive,
  input  logic        Squirtle_Alive,
  input  logic [31:0] Health_Charmander,
  input  logic [31:0] Health_Squirtle,
  output logic [15:0] oled_data,
  output logic        pixel_valid
);

  function automatic logic [5:0] bar_len(input logic [6:0] h);
    return 6'(({9'd0, h} * 16'(BAR_MAX)) / 16'd100);
  endfunction

  localparam snap_t SNAP_RST = '{
    top_c:   6'd19,
    top_s:   6'd19,
    fb_en:   '0,
    wb_en:   '0,
    fb_x:    {NUM_BALLS{7'd17}},
    wb_x:    {NUM_BALLS{7'd74}},
    shield:  '0,
    alive_c: 1'b1,
    alive_s: 1'b1,
    bar_c:   6'(BAR_MAX),
    bar_s:   6'(BAR_MAX)
  };

  snap_t       snap_q, snap_d;
  logic [6:0]  hc_in, hs_in;
  logic        flash_c, flash_s;
  logic [6:0]  x0_q, x0_d, y0_q, y0_d;
  logic        oob0_q, oob0_d, valid0_q, valid0_d;
  hit_t        hit1_q, hit1_d;
  logic        valid1_q, valid1_d;
  logic [15:0] oled_q, oled_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [7:0]  px, py;
  logic        c_box, s_box;

  assign hc_in = clamp_health(Health_Charmander);
  assign hs_in = clamp_health(Health_Squirtle);

  // Whole game state is captured on the frame strobe so a frame never tears.
  always_comb begin
    snap_d = snap_q;
    if (frame_begin) begin
      snap_d.top_c   = topYCharmander;
      snap_d.top_s   = topYSquirtle;
      snap_d.fb_en   = FireBall_EN;
      snap_d.wb_en   = WaterBall_EN;
      snap_d.fb_x    = leftX_fb_flat;
      snap_d.wb_x    = leftX_wb_flat;
      snap_d.shield  = Shield_EN;
      snap_d.alive_c = Charmander_Alive;
      snap_d.alive_s = Squirtle_Alive;
      snap_d.bar_c   = bar_len(hc_in);
      snap_d.bar_s   = bar_len(hs_in);
    end
  end

  pokemon_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash_c (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .health(hc_in), .flash(flash_c)
  );

  pokemon_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash_s (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .health(hs_in), .flash(flash_s)
  );

  // Stage 0: split the linear index into x/y and flag off-screen requests.
  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    oob0_d   = oob0_q;
    valid0_d = pixel_req;
    if (pixel_req) begin
      x0_d   = 7'(pixel_index % 13'(SCREEN_W));
      y0_d   = 7'(pixel_index / 13'(SCREEN_W));
      oob0_d = (pixel_index >= 13'(PIXELS));
    end
  end

  assign px    = {1'b0, x0_q};
  assign py    = {1'b0, y0_q};
  assign c_box = in_span(px, CHAR_C_X0, CHAR_C_X1) &&
                 in_span(py, {2'b00, snap_q.top_c}, {2'b00, snap_q.top_c} + 8'(CHAR_H - 1));
  assign s_box = in_span(px, CHAR_S_X0, CHAR_S_X1) &&
                 in_span(py, {2'b00, snap_q.top_s}, {2'b00, snap_q.top_s} + 8'(CHAR_H - 1));

  // Stage 1: test every layer against the snapshot current in this cycle.
  always_comb begin
    hit1_d    = '0;
    valid1_d  = valid0_q;
    hit1_d.oob = oob0_q;
    hit1_d.hp  = (py == 8'd0) &&
                 ((px < {2'b00, snap_q.bar_c}) ||
                  ((snap_q.bar_s != 6'd0) && (px >= 8'(SCREEN_W) - {2'b00, snap_q.bar_s})));
    for (int l = 0; l < 3; l++) begin
      if (in_span(py, LANE_TOP[l], LANE_TOP[l] + 8'(CHAR_H - 1))) begin
        if (snap_q.shield[l] && in_span(px, SHIELD_C_X0, SHIELD_C_X1)) hit1_d.shield = 1'b1;
        if (snap_q.shield[3+l] && in_span(px, SHIELD_S_X0, SHIELD_S_X1)) hit1_d.shield = 1'b1;
      end
    end
    hit1_d.chr_c     = c_box;
    hit1_d.chr_s     = s_box;
    hit1_d.chr_dead  = (c_box && !snap_q.alive_c) || (s_box && !snap_q.alive_s);
    hit1_d.chr_white = (c_box && snap_q.alive_c && flash_c) ||
                       (s_box && snap_q.alive_s && flash_s);
    for (int n = 0; n < NUM_BALLS; n++) begin
      if (in_span(py, BALL_TOP[n/4], BALL_TOP[n/4] + 8'(BALL_SIZE - 1))) begin
        if (snap_q.fb_en[n] &&
            in_span(px, {1'b0, snap_q.fb_x[n]}, {1'b0, snap_q.fb_x[n]} + 8'(BALL_SIZE - 1)))
          hit1_d.fire = 1'b1;
        if (snap_q.wb_en[n] &&
            in_span(px, {1'b0, snap_q.wb_x[n]}, {1'b0, snap_q.wb_x[n]} + 8'(BALL_SIZE - 1)))
          hit1_d.water = 1'b1;
      end
    end
  end

  // Stage 2: priority mux; fire beats water where balls overlap.
  always_comb begin
    oled_d        = oled_q;
    pixel_valid_d = valid1_q;
    if (valid1_q) begin
      if (hit1_q.oob)                      oled_d = COL_BG;
      else if (hit1_q.hp)                  oled_d = COL_HP;
      else if (hit1_q.shield)              oled_d = COL_SHIELD;
      else if (hit1_q.chr_c || hit1_q.chr_s) begin
        if (hit1_q.chr_dead)               oled_d = COL_DEAD;
        else if (hit1_q.chr_white)         oled_d = COL_WHITE;
        else if (hit1_q.chr_c)             oled_d = COL_CHAR;
        else                               oled_d = COL_SQUIR;
      end
      else if (hit1_q.fire)                oled_d = COL_FIRE;
      else if (hit1_q.water)               oled_d = COL_WATER;
      else                                 oled_d = COL_BG;
    end
  end

  // All state registers; reset empties the pipeline at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q        <= SNAP_RST;
      x0_q          <= 7'd0;
      y0_q          <= 7'd0;
      oob0_q        <= 1'b0;
      valid0_q      <= 1'b0;
      hit1_q        <= '0;
      valid1_q      <= 1'b0;
      oled_q        <= 16'h0000;
      pixel_valid_q <= 1'b0;
    end else begin
      snap_q        <= snap_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      oob0_q        <= oob0_d;
      valid0_q      <= valid0_d;
      hit1_q        <= hit1_d;
      valid1_q      <= valid1_d;
      oled_q        <= oled_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign oled_data   = oled_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_pokemon_frame_renderer.sv
// Directed bench for pokemon_frame_renderer.
// Drives on the falling edge, samples on the falling edge after the result edge.
// Expected colours are hand-derived from the frame geometry.
module tb_pokemon_frame_renderer;

  localparam logic [15:0] BG     = 16'h0000;
  localparam logic [15:0] FIRE   = 16'hF800;
  localparam logic [15:0] WATER  = 16'h001F;
  localparam logic [15:0] CHAR   = 16'hFC00;
  localparam logic [15:0] SQUIR  = 16'h07FF;
  localparam logic [15:0] SHIELD = 16'hFFE0;
  localparam logic [15:0] HP     = 16'h07E0;
  localparam logic [15:0] DEAD   = 16'h8410;
  localparam logic [15:0] WHITE  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] pixel_index;
  logic        pixel_req;
  logic        frame_begin;
  logic [5:0]  topYCharmander, topYSquirtle;
  logic [11:0] FireBall_EN, WaterBall_EN;
  logic [83:0] leftX_fb_flat, leftX_wb_flat;
  logic [5:0]  Shield_EN;
  logic        Charmander_Alive, Squirtle_Alive;
  logic [31:0] Health_Charmander, Health_Squirtle;
  logic [15:0] oled_data;
  logic        pixel_valid;

  int tests = 0;
  int fails = 0;
  logic [7:0] white_pat;

  always #5 clk = ~clk;

  pokemon_frame_renderer dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_index(pixel_index), .pixel_req(pixel_req), .frame_begin(frame_begin),
    .topYCharmander(topYCharmander), .topYSquirtle(topYSquirtle),
    .FireBall_EN(FireBall_EN), .WaterBall_EN(WaterBall_EN),
    .leftX_fb_flat(leftX_fb_flat), .leftX_wb_flat(leftX_wb_flat),
    .Shield_EN(Shield_EN),
    .Charmander_Alive(Charmander_Alive), .Squirtle_Alive(Squirtle_Alive),
    .Health_Charmander(Health_Charmander), .Health_Squirtle(Health_Squirtle),
    .oled_data(oled_data), .pixel_valid(pixel_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk); frame_begin = 1'b1;
    @(negedge clk); frame_begin = 1'b0;
  endtask

  // Single request; result is visible after the third rising edge.
  task automatic pix(input string tag, input int x, input int y, input logic [15:0] exp);
    @(negedge clk); pixel_index = 13'(y * 96 + x); pixel_req = 1'b1;
    @(negedge clk); pixel_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, pixel_valid}, 32'd1);
    chk(tag, {16'd0, oled_data}, {16'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; pixel_index = '0; pixel_req = 1'b0; frame_begin = 1'b0;
    topYCharmander = 6'd19; topYSquirtle = 6'd19;
    FireBall_EN = '0; WaterBall_EN = '0; leftX_fb_flat = '0; leftX_wb_flat = '0;
    Shield_EN = '0; Charmander_Alive = 1'b1; Squirtle_Alive = 1'b1;
    Health_Charmander = 32'd100; Health_Squirtle = 32'd100;
    white_pat = 8'b0011_0011;

    repeat (2) @(negedge clk);
    chk("rst_vld", {31'd0, pixel_valid}, 32'd0);
    chk("rst_data", {16'd0, oled_data}, 32'd0);
    rst_n = 1'b1;

    // First pixel: exact two-cycle latency from the capture edge.
    @(negedge clk); pixel_index = 13'd0; pixel_req = 1'b1;
    @(negedge clk); pixel_req = 1'b0;
    @(negedge clk); chk("lat_early", {31'd0, pixel_valid}, 32'd0);
    @(negedge clk); chk("lat_vld", {31'd0, pixel_valid}, 32'd1);
    chk("lat_hp", {16'd0, oled_data}, {16'd0, HP});
    @(negedge clk); chk("lat_drop", {31'd0, pixel_valid}, 32'd0);

    // Reset snapshot: full bars, characters at row 19.
    pix("rst_sq_bar_end", 95, 0, HP);
    pix("rst_sq_bar_gap", 55, 0, BG);
    pix("rst_sq_bar_start", 56, 0, HP);
    pix("rst_char", 5, 20, CHAR);
    pix("rst_squir", 85, 20, SQUIR);
    pix("rst_char_above", 5, 18, BG);
    pix("rst_char_last", 5, 36, CHAR);
    pix("rst_char_below", 5, 37, BG);

    // Fireball 4 at x=30 in the middle lane.
    FireBall_EN = 12'h010; leftX_fb_flat[28 +: 7] = 7'd30;
    frame();
    pix("fb_hit", 33, 27, FIRE);
    pix("fb_right_out", 38, 27, BG);
    pix("fb_tl", 30, 24, FIRE);
    pix("fb_br", 37, 31, FIRE);
    pix("fb_left_out", 29, 27, BG);
    pix("fb_below_out", 33, 32, BG);

    // Inputs change without a strobe: stale snapshot must persist.
    FireBall_EN = '0;
    pix("hold_snapshot", 33, 27, FIRE);
    frame();
    pix("new_snapshot", 33, 27, BG);

    // Fire/water overlap and character over fireball.
    FireBall_EN = 12'h030; leftX_fb_flat[35 +: 7] = 7'd10;
    WaterBall_EN = 12'h020; leftX_wb_flat[35 +: 7] = 7'd34;
    frame();
    pix("overlap_fire", 35, 27, FIRE);
    pix("water_only", 40, 27, WATER);
    pix("water_br", 41, 31, WATER);
    pix("water_out", 42, 27, BG);
    pix("char_over_fire", 12, 26, CHAR);
    pix("fire_beside_char", 17, 26, FIRE);
    FireBall_EN = '0; WaterBall_EN = '0;

    // Health drop 100 -> 80: counter 8, then 7..0 over eight frames.
    Health_Charmander = 32'd80;
    frame();
    pix("flash_f0", 5, 20, CHAR);
    pix("bar80_lit", 31, 0, HP);
    pix("bar80_dark", 32, 0, BG);
    for (int k = 1; k <= 8; k++) begin
      frame();
      pix($sformatf("flash_f%0d", k), 5, 20, white_pat[k-1] ? WHITE : CHAR);
    end
    frame();
    pix("flash_done", 5, 20, CHAR);

    // Clamp above 100 and zero-length bar.
    Health_Charmander = 32'd200;
    frame();
    pix("clamp_lit", 39, 0, HP);
    pix("clamp_dark", 40, 0, BG);
    Health_Charmander = 32'd0;
    frame();
    pix("bar_zero", 0, 0, BG);

    // Shields, dead Squirtle, dead does not flash.
    Shield_EN = 6'b100001; Squirtle_Alive = 1'b0; topYSquirtle = 6'd37;
    Health_Squirtle = 32'd50;
    frame();
    pix("sq_shield", 77, 40, SHIELD);
    pix("sq_dead", 85, 40, DEAD);
    pix("sq_shield_last", 78, 54, SHIELD);
    pix("sq_shield_below", 78, 55, BG);
    pix("sq_shield_left", 76, 40, BG);
    pix("ch_shield", 17, 5, SHIELD);
    pix("ch_shield_top", 18, 1, SHIELD);
    pix("ch_lane1_off", 17, 19, BG);
    frame();
    pix("dead_no_flash", 85, 40, DEAD);

    // Squirtle revived at row 50 while its counter is 6, then 5.
    Shield_EN = '0; Squirtle_Alive = 1'b1;
    topYCharmander = 6'd50; topYSquirtle = 6'd50;
    frame();
    pix("sq_flash", 85, 55, WHITE);
    frame();

    // Back-to-back requests across the end of the screen.
    @(negedge clk); pixel_index = 13'd6142; pixel_req = 1'b1;
    @(negedge clk); pixel_index = 13'd6143;
    @(negedge clk); pixel_index = 13'd6144;
    @(negedge clk); pixel_index = 13'd6149;
    chk("bb6142_vld", {31'd0, pixel_valid}, 32'd1);
    chk("bb6142", {16'd0, oled_data}, {16'd0, SQUIR});
    @(negedge clk); pixel_req = 1'b0;
    chk("bb6143_vld", {31'd0, pixel_valid}, 32'd1);
    chk("bb6143", {16'd0, oled_data}, {16'd0, BG});
    @(negedge clk);
    chk("bb6144_vld", {31'd0, pixel_valid}, 32'd1);
    chk("bb6144", {16'd0, oled_data}, {16'd0, BG});
    @(negedge clk);
    chk("bb6149_vld", {31'd0, pixel_valid}, 32'd1);
    chk("bb6149", {16'd0, oled_data}, {16'd0, BG});
    @(negedge clk);
    chk("bb_idle", {31'd0, pixel_valid}, 32'd0);

    // Reset in the middle of a streaming burst.
    @(negedge clk); pixel_index = 13'd0; pixel_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream_vld", {31'd0, pixel_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_vld", {31'd0, pixel_valid}, 32'd0);
    chk("mid_rst_data", {16'd0, oled_data}, 32'd0);
    pixel_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", c), {31'd0, pixel_valid}, 32'd0);
    end
    pix("post_rst_char", 5, 20, CHAR);
    pix("post_rst_bar", 0, 0, HP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
